// File: rtl/ifconv_sched_if.sv
// ifconv_sched_if: issue ports, converter drive/return and writeback slot of the int-to-float scheduler
interface ifconv_sched_if #(
  parameter int NREQ = 2,
  parameter int TAGW = 9
);
  logic [NREQ-1:0]      req_vld;
  logic [NREQ*65-1:0]   req_A;
  logic [NREQ*2-1:0]    req_typ;
  logic [NREQ-1:0]      req_isS;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ-1:0]      req_rdy;
  logic                 cv_en;
  logic                 cv_clkEn;
  logic [64:0]          cv_A;
  logic                 cv_isS;
  logic                 cv_toSNG;
  logic                 cv_toDBL;
  logic                 cv_toEXT;
  logic [81:0]          cv_res;
  logic [1:0]           cv_rtyp;
  logic                 flush;
  logic                 out_vld;
  logic                 out_rdy;
  logic [81:0]          out_res;
  logic [1:0]           out_rtyp;
  logic [TAGW-1:0]      out_tag;
  logic                 out_exc;
  modport slave (
    input  req_vld, req_A, req_typ, req_isS, req_tag, cv_res, cv_rtyp, flush, out_rdy,
    output req_rdy, cv_en, cv_clkEn, cv_A, cv_isS, cv_toSNG, cv_toDBL, cv_toEXT,
           out_vld, out_res, out_rtyp, out_tag, out_exc
  );
  modport master (
    output req_vld, req_A, req_typ, req_isS, req_tag, cv_res, cv_rtyp, flush, out_rdy,
    input  req_rdy, cv_en, cv_clkEn, cv_A, cv_isS, cv_toSNG, cv_toDBL, cv_toEXT,
           out_vld, out_res, out_rtyp, out_tag, out_exc
  );
endinterface

// File: rtl/ifconv_sched.sv
// ifconv_sched: round-robin issue, tag shadow pipe and writeback slot for ifconv_mod; IFCONV_SCHED_PERF_EN adds perf counters
module ifconv_sched #(
  parameter int NREQ = 2,
  parameter int TAGW = 9,
  parameter int LAT  = 2
) (
  input logic clk,
  input logic rst,
  ifconv_sched_if.slave bus
`ifdef IFCONV_SCHED_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_busy
`endif
);
  localparam int LW = $clog2(NREQ);
  logic            advance, any, exc;
  logic [LW-1:0]   last, gidx;
  logic [1:0]      typ;
  logic [LAT-1:0]  svld, sexc;
  logic [TAGW-1:0] stag [LAT];
  int              idx;
  assign advance = ~(bus.out_vld & ~bus.out_rdy);
  assign any     = advance & ~bus.flush & ~rst & |bus.req_vld;
  // first requester after last wins; scanning backwards lets the nearest one overwrite
  always_comb begin
    gidx = last;
    idx  = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (bus.req_vld[idx]) gidx = LW'(idx);
    end
  end
  assign typ          = bus.req_typ[int'(gidx)*2 +: 2];
  assign exc          = typ == 2'b11;
  assign bus.req_rdy  = any ? NREQ'(1) << gidx : '0;
  assign bus.cv_en    = any;
  assign bus.cv_clkEn = advance & ~rst;
  assign bus.cv_A     = any & ~exc ? bus.req_A[int'(gidx)*65 +: 65] : '0;
  assign bus.cv_isS   = any & bus.req_isS[gidx];
  assign bus.cv_toSNG = any & (typ == 2'b00);
  assign bus.cv_toDBL = any & (typ == 2'b01);
  assign bus.cv_toEXT = any & (typ == 2'b10);
  // pointer moves only on an accepted grant
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= LW'(NREQ-1);
    else if (any) last <= gidx;
  // shadow of the converter's register stages, frozen together with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      svld <= '0;
      sexc <= '0;
      for (int k = 0; k < LAT; k++) stag[k] <= '0;
    end else if (bus.flush) begin
      svld <= '0;
    end else if (advance) begin
      svld    <= {svld[LAT-2:0], any};
      sexc    <= {sexc[LAT-2:0], exc};
      stag[0] <= bus.req_tag[int'(gidx)*TAGW +: TAGW];
      for (int k = 1; k < LAT; k++) stag[k] <= stag[k-1];
    end
  end
  // writeback slot: replace on capture, drop once consumed, flush wins over capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_vld  <= 1'b0;
      bus.out_res  <= '0;
      bus.out_rtyp <= '0;
      bus.out_tag  <= '0;
      bus.out_exc  <= 1'b0;
    end else if (bus.flush) begin
      bus.out_vld <= 1'b0;
    end else if (advance) begin
      bus.out_vld <= svld[LAT-1];
      if (svld[LAT-1]) begin
        bus.out_res  <= sexc[LAT-1] ? '0 : bus.cv_res;
        bus.out_rtyp <= sexc[LAT-1] ? '0 : bus.cv_rtyp;
        bus.out_tag  <= stag[LAT-1];
        bus.out_exc  <= sexc[LAT-1];
      end
    end
  end
`ifdef IFCONV_SCHED_PERF_EN
  // free-running wrapping counters, untouched by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
      perf_busy   <= '0;
    end else begin
      perf_issued <= perf_issued + 32'(any);
      perf_stall  <= perf_stall + 32'(~advance);
      perf_busy   <= perf_busy + 32'(|svld | bus.out_vld);
    end
  end
`else
`endif
endmodule

// File: tb/tb_ifconv_sched.sv
// tb_ifconv_sched: directed steps with a transaction scoreboard around a two-stage mock converter
module tb_ifconv_sched;
  logic clk, rst;
  int total = 0, bad = 0;
  logic [93:0] q[$];
  logic [93:0] sb_e;
  logic [81:0] s1_res, s2_res;
  logic [1:0]  s1_t, s2_t;
  logic [8:0]  rr_t [4];
  ifconv_sched_if #(.NREQ(2), .TAGW(9)) bus ();
  ifconv_sched #(.NREQ(2), .TAGW(9), .LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // mock converter: two clock-enabled register stages, result encodes its inputs
  always @(posedge clk)
    if (bus.cv_clkEn) begin
      s1_res <= {13'b0, bus.cv_isS, bus.cv_toSNG, bus.cv_toDBL, bus.cv_toEXT, bus.cv_A};
      s1_t   <= bus.cv_toDBL ? 2'd1 : bus.cv_toEXT ? 2'd2 : 2'd0;
      s2_res <= s1_res;
      s2_t   <= s1_t;
    end
  assign bus.cv_res  = s2_res;
  assign bus.cv_rtyp = s2_t;
  function automatic logic [93:0] exp_of(logic [64:0] a, logic [1:0] t, logic s, logic [8:0] g);
    if (t == 2'b11) return {g, 1'b1, 2'b0, 82'b0};
    return {g, 1'b0, t == 2'd1 ? 2'd1 : t == 2'd2 ? 2'd2 : 2'd0,
            13'b0, s, t == 2'd0, t == 2'd1, t == 2'd2, a};
  endfunction
  task automatic chk(input string nm, input logic [127:0] o, input logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, o, e);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  task automatic idle;
    bus.req_vld = '0;
  endtask
  task automatic put(input int p, input logic [64:0] a, input logic [1:0] t, input logic s, input logic [8:0] g);
    bus.req_vld[p]         = 1'b1;
    bus.req_A[p*65 +: 65]  = a;
    bus.req_typ[p*2 +: 2]  = t;
    bus.req_isS[p]         = s;
    bus.req_tag[p*9 +: 9]  = g;
  endtask
  // scoreboard: pop on handshake, drop on flush/reset, push on transfer
  always @(negedge clk) begin
    if (bus.out_vld && bus.out_rdy) begin
      sb_e = q.size() != 0 ? q.pop_front() : '1;
      chk("sb", {bus.out_tag, bus.out_exc, bus.out_rtyp, bus.out_res}, sb_e);
    end
    if (rst || bus.flush) q.delete();
    for (int p = 0; p < 2; p++)
      if (bus.req_vld[p] && bus.req_rdy[p])
        q.push_back(exp_of(bus.req_A[p*65 +: 65], bus.req_typ[p*2 +: 2], bus.req_isS[p], bus.req_tag[p*9 +: 9]));
  end
  initial begin
    rr_t = '{9'h10, 9'h21, 9'h12, 9'h23};
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_rdy = 1'b1;
    bus.req_vld = '0;
    bus.req_A = '0;
    bus.req_typ = '0;
    bus.req_isS = '0;
    bus.req_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.req_vld = 2'b11;
    smp;
    chk("rst_rdy", bus.req_rdy, 0);
    chk("rst_cv_en", bus.cv_en, 0);
    chk("rst_clken", bus.cv_clkEn, 0);
    chk("rst_cv_A", bus.cv_A, 0);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out", {bus.out_res, bus.out_rtyp, bus.out_tag, bus.out_exc}, 0);
    nxt;
    rst = 1'b0;
    idle;
    nxt;
    put(0, 65'd5, 2'b01, 1'b0, 9'd3);
    smp;
    chk("single_rdy", bus.req_rdy, 2'b01);
    chk("single_sel", {bus.cv_toSNG, bus.cv_toDBL, bus.cv_toEXT}, 3'b010);
    chk("single_cvA", bus.cv_A, 5);
    nxt;
    idle;
    smp;
    chk("single_t1", bus.out_vld, 0);
    nxt;
    smp;
    chk("single_t2", bus.out_vld, 0);
    nxt;
    smp;
    chk("single_t3", bus.out_vld, 1);
    chk("single_tag", bus.out_tag, 3);
    chk("single_res", bus.out_res, {13'b0, 1'b0, 3'b010, 65'd5});
    chk("single_rtyp", bus.out_rtyp, 1);
    nxt;
    put(1, 65'd123, 2'b11, 1'b1, 9'd7);
    smp;
    chk("ill_rdy", bus.req_rdy, 2'b10);
    chk("ill_sel", {bus.cv_toSNG, bus.cv_toDBL, bus.cv_toEXT, bus.cv_en}, 4'b0001);
    chk("ill_cvA", bus.cv_A, 0);
    nxt;
    idle;
    nxt;
    nxt;
    smp;
    chk("ill_vld", bus.out_vld, 1);
    chk("ill_exc", bus.out_exc, 1);
    chk("ill_res", {bus.out_res, bus.out_rtyp}, 0);
    chk("ill_tag", bus.out_tag, 7);
    for (int k = 0; k < 8; k++) begin
      nxt;
      idle;
      if (k < 4) begin
        put(0, 65'(100 + k), 2'b01, 1'b0, 9'(16 + k));
        put(1, 65'(200 + k), 2'b10, 1'b1, 9'(32 + k));
      end
      smp;
      if (k < 4) chk($sformatf("rr_rdy%0d", k), bus.req_rdy, (k % 2) != 0 ? 2'b10 : 2'b01);
      if (k >= 3 && k < 7) begin
        chk($sformatf("rr_vld%0d", k), bus.out_vld, 1);
        chk($sformatf("rr_tag%0d", k), bus.out_tag, rr_t[k-3]);
      end
    end
    for (int c = 0; c < 12; c++) begin
      nxt;
      idle;
      bus.out_rdy = !(c >= 3 && c <= 7);
      if (c < 3) put(0, 65'(300 + c), 2'b00, 1'b1, 9'(48 + c));
      else if (c <= 8) put(0, 65'd333, 2'b01, 1'b0, 9'h33);
      smp;
      if (c >= 3 && c <= 7) begin
        chk($sformatf("bp_vld%0d", c), bus.out_vld, 1);
        chk($sformatf("bp_tag%0d", c), bus.out_tag, 9'h30);
        chk($sformatf("bp_clken%0d", c), bus.cv_clkEn, 0);
        chk($sformatf("bp_rdy%0d", c), bus.req_rdy, 0);
      end
      if (c == 8) begin
        chk("bp_rel_rdy", bus.req_rdy, 2'b01);
        chk("bp_rel_tag", bus.out_tag, 9'h30);
      end
      if (c >= 9) chk($sformatf("bp_after%0d", c), {bus.out_vld, bus.out_tag}, {1'b1, 9'(48 + c - 8)});
    end
    for (int c = 0; c < 7; c++) begin
      nxt;
      idle;
      bus.flush = (c == 2);
      if (c < 2) put(0, 65'(400 + c), 2'b01, 1'b1, 9'(64 + c));
      else if (c <= 3) put(0, 65'd442, 2'b10, 1'b0, 9'h42);
      smp;
      if (c == 2) chk("fl_rdy_flush", bus.req_rdy, 0);
      if (c == 3) chk("fl_rdy_next", bus.req_rdy, 2'b01);
      if (c >= 2 && c <= 5) chk($sformatf("fl_vld%0d", c), bus.out_vld, 0);
      if (c == 6) chk("fl_next_res", {bus.out_vld, bus.out_tag}, {1'b1, 9'h42});
    end
    nxt;
    idle;
    put(0, 65'd500, 2'b01, 1'b0, 9'h50);
    smp;
    chk("rm_rdy0", bus.req_rdy, 2'b01);
    nxt;
    idle;
    put(0, 65'd501, 2'b01, 1'b0, 9'h51);
    nxt;
    idle;
    rst = 1'b1;
    put(0, 65'd600, 2'b01, 1'b0, 9'h60);
    put(1, 65'd601, 2'b01, 1'b0, 9'h61);
    smp;
    chk("rm_rdy", bus.req_rdy, 0);
    chk("rm_cv", {bus.cv_en, bus.cv_toDBL, bus.cv_A}, 0);
    chk("rm_out", {bus.out_vld, bus.out_res, bus.out_tag}, 0);
    nxt;
    rst = 1'b0;
    smp;
    chk("rm_first_grant", bus.req_rdy, 2'b01);
    nxt;
    idle;
    smp;
    chk("rm_t1", bus.out_vld, 0);
    nxt;
    smp;
    chk("rm_t2", bus.out_vld, 0);
    nxt;
    smp;
    chk("rm_t3", {bus.out_vld, bus.out_tag}, {1'b1, 9'h60});
    nxt;
    nxt;
    smp;
    chk("sb_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
